// File: rtl/umi_pack_tx.sv
`default_nettype none
// ============================================================================
//  Module      : umi_pack_tx
//  Description : Transmit-side UMI packer. Assembles the 256-bit UMI packet
//                from decoded command fields, addresses and write data, and
//                presents it through a registered output stage backed by a
//                one-entry skid register. Commands with opcode 0 are
//                consumed and dropped.
//  Ports       : clk, reset                 - clock, synchronous active-high reset
//                in_valid / in_ready        - request handshake
//                cmd_opcode/size/user       - command word fields
//                dstaddr, srcaddr, data     - packet payload
//                out_valid / out_ready      - packet handshake
//                packet_out                 - assembled packet
//                tx_count                   - delivered packets (wraps)
//                drop_count                 - dropped commands (saturates)
//  Revision    : 1.0 - initial release
// ============================================================================
module umi_pack_tx #(
    parameter int AW = 64,
    parameter int PW = 256,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [7:0]    cmd_opcode,
    input  logic [3:0]    cmd_size,
    input  logic [19:0]   cmd_user,
    input  logic [AW-1:0] dstaddr,
    input  logic [AW-1:0] srcaddr,
    input  logic [95:0]   data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [PW-1:0] packet_out,
    output logic [CW-1:0] tx_count,
    output logic [CW-1:0] drop_count
);

    localparam int c_PKT_W     = 256;
    localparam bit c_SUPPORTED = (AW == 64) && (PW == 256);

    logic [c_PKT_W-1:0] w_packet;
    logic [c_PKT_W-1:0] r_ob_data;
    logic [c_PKT_W-1:0] r_sb_data;
    logic               r_ob_valid;
    logic               r_sb_valid;
    logic               r_in_ready;
    logic [CW-1:0]      r_tx_count;
    logic [CW-1:0]      r_drop_count;

    logic w_accept;
    logic w_valid_accept;
    logic w_drop;
    logic w_drain;
    logic w_tx;
    logic w_ob_valid_nxt;
    logic w_ob_load_in;
    logic w_ob_load_sb;
    logic w_sb_valid_nxt;
    logic w_sb_load;

    // Packet assembly and output mapping exist only for the supported
    // geometry; any other combination presents an idle, all-zero port.
    generate
        if (c_SUPPORTED) begin : g_supported
            assign w_packet = {dstaddr[63:32],
                               srcaddr[63:32],
                               data[95:64],
                               data[63:32],
                               data[31:0],
                               srcaddr[31:0],
                               dstaddr[31:0],
                               cmd_user,
                               cmd_size,
                               cmd_opcode};
            assign packet_out = r_ob_data;
            assign out_valid  = r_ob_valid;
        end else begin : g_unsupported
            assign w_packet   = '0;
            assign packet_out = '0;
            assign out_valid  = 1'b0;
        end
    endgenerate

    assign in_ready       = r_in_ready;
    assign w_accept       = in_valid & r_in_ready;
    assign w_valid_accept = w_accept & (cmd_opcode != 8'h00) & c_SUPPORTED;
    assign w_drop         = w_accept & (cmd_opcode == 8'h00);
    // OB can take a new entry when it is empty or its current packet leaves.
    assign w_drain        = ~r_ob_valid | out_ready;
    assign w_tx           = out_valid & out_ready;

    // Buffer steering: SB always feeds OB first so ordering stays FIFO.
    always_comb begin
        w_ob_valid_nxt = r_ob_valid;
        w_ob_load_in   = 1'b0;
        w_ob_load_sb   = 1'b0;
        w_sb_valid_nxt = r_sb_valid;
        w_sb_load      = 1'b0;
        if (w_drain) begin
            if (r_sb_valid) begin
                w_ob_valid_nxt = 1'b1;
                w_ob_load_sb   = 1'b1;
                w_sb_valid_nxt = w_valid_accept;
                w_sb_load      = w_valid_accept;
            end else begin
                w_ob_valid_nxt = w_valid_accept;
                w_ob_load_in   = w_valid_accept;
            end
        end else if (w_valid_accept) begin
            w_sb_valid_nxt = 1'b1;
            w_sb_load      = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ob_valid <= 1'b0;
            r_ob_data  <= '0;
            r_sb_valid <= 1'b0;
            r_sb_data  <= '0;
            r_in_ready <= 1'b1;
        end else begin
            r_ob_valid <= w_ob_valid_nxt;
            r_sb_valid <= w_sb_valid_nxt;
            // in_ready is registered from the next SB state so out_ready
            // never reaches it combinationally.
            r_in_ready <= ~w_sb_valid_nxt;
            if (w_ob_load_sb) begin
                r_ob_data <= r_sb_data;
            end else if (w_ob_load_in) begin
                r_ob_data <= w_packet;
            end
            if (w_sb_load) begin
                r_sb_data <= w_packet;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx_count   <= '0;
            r_drop_count <= '0;
        end else begin
            if (w_tx) begin
                r_tx_count <= r_tx_count + 1'b1;
            end
            if (w_drop && (r_drop_count != {CW{1'b1}})) begin
                r_drop_count <= r_drop_count + 1'b1;
            end
        end
    end

    assign tx_count   = r_tx_count;
    assign drop_count = r_drop_count;

endmodule
`default_nettype wire

// File: tb/tb_umi_pack_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_umi_pack_tx
//  Description : Self-checking bench for umi_pack_tx. A scoreboard queue is
//                filled from accepted valid requests and drained as packets
//                leave the DUT; scenario tasks check handshake timing and
//                counters. Counter width is reduced so wrap and saturation
//                are reachable in a short run.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_umi_pack_tx;

    localparam int AW = 64;
    localparam int PW = 256;
    localparam int CW = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    cmd_opcode;
    logic [3:0]    cmd_size;
    logic [19:0]   cmd_user;
    logic [AW-1:0] dstaddr;
    logic [AW-1:0] srcaddr;
    logic [95:0]   data;
    logic          out_valid;
    logic          out_ready;
    logic [PW-1:0] packet_out;
    logic [CW-1:0] tx_count;
    logic [CW-1:0] drop_count;

    int n_tests = 0;
    int n_fail  = 0;

    logic [255:0] sb_q[$];
    logic [255:0] exp_pkt;

    umi_pack_tx #(.AW(AW), .PW(PW), .CW(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .cmd_opcode (cmd_opcode),
        .cmd_size   (cmd_size),
        .cmd_user   (cmd_user),
        .dstaddr    (dstaddr),
        .srcaddr    (srcaddr),
        .data       (data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .packet_out (packet_out),
        .tx_count   (tx_count),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    function automatic logic [255:0] build_pkt(input logic [7:0] op, input logic [3:0] sz,
                                               input logic [19:0] usr, input logic [63:0] dst,
                                               input logic [63:0] src, input logic [95:0] d);
        logic [255:0] p;
        p[7:0]     = op;
        p[11:8]    = sz;
        p[31:12]   = usr;
        p[63:32]   = dst[31:0];
        p[95:64]   = src[31:0];
        p[127:96]  = d[31:0];
        p[159:128] = d[63:32];
        p[191:160] = d[95:64];
        p[223:192] = src[63:32];
        p[255:224] = dst[63:32];
        return p;
    endfunction

    // Scoreboard: compare departing packets first, then record this cycle's
    // accepted request (it can only appear on a later cycle).
    always @(negedge clk) begin
        if (reset) begin
            sb_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                n_tests++;
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL scoreboard_extra: got packet %h, required no packet", packet_out);
                end else begin
                    exp_pkt = sb_q.pop_front();
                    if (packet_out !== exp_pkt) begin
                        n_fail++;
                        $display("FAIL scoreboard_pkt: got %h, required %h", packet_out, exp_pkt);
                    end
                end
            end
            if (in_valid && in_ready && cmd_opcode != 8'h00)
                sb_q.push_back(build_pkt(cmd_opcode, cmd_size, cmd_user, dstaddr, srcaddr, data));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_valid();
        cmd_opcode = 8'($urandom_range(1, 255));
        cmd_size   = 4'($urandom);
        cmd_user   = 20'($urandom);
        dstaddr    = {$urandom, $urandom};
        srcaddr    = {$urandom, $urandom};
        data       = {$urandom, $urandom, $urandom};
    endtask

    // Presents the current fields until accepted (bounded), then deasserts.
    task automatic send_one();
        int k;
        k = 0;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && k < 20) begin
            tick();
            @(negedge clk);
            k++;
        end
        n_tests++;
        if (!in_ready) begin
            n_fail++;
            $display("FAIL send_timeout: in_ready=%b after %0d cycles, required 1", in_ready, k);
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        cmd_opcode = '0; cmd_size = '0; cmd_user = '0;
        dstaddr = '0; srcaddr = '0; data = '0;
        repeat (3) tick();
        reset = 1'b0;
        @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
        n_tests++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b, required 1", in_ready); end
        n_tests++;
        if (packet_out !== '0) begin n_fail++; $display("FAIL reset_packet: got %h, required 0", packet_out); end
        n_tests++;
        if (tx_count !== '0 || drop_count !== '0) begin
            n_fail++;
            $display("FAIL reset_counters: got tx=%0d drop=%0d, required 0 0", tx_count, drop_count);
        end
        tick();
    endtask

    task automatic test_single();
        logic [255:0] lit;
        lit = {32'h11112222, 32'h55556666, 32'hCCCC0003, 32'hBBBB0002,
               32'hAAAA0001, 32'h77778888, 32'h33334444, 32'hABCDE321};
        out_ready  = 1'b1;
        cmd_opcode = 8'h21; cmd_size = 4'h3; cmd_user = 20'hABCDE;
        dstaddr = 64'h11112222_33334444; srcaddr = 64'h55556666_77778888;
        data = 96'hCCCC0003_BBBB0002_AAAA0001;
        send_one();
        @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_latency: out_valid=%b, required 1", out_valid); end
        n_tests++;
        if (packet_out !== lit) begin n_fail++; $display("FAIL single_layout: got %h, required %h", packet_out, lit); end
        tick();
        @(negedge clk);
        n_tests++;
        if (tx_count !== 10'd1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_tx: got tx=%0d out_valid=%b, required 1 0", tx_count, out_valid);
        end
        tick();
    endtask

    task automatic test_backpressure();
        logic [CW-1:0] t0;
        logic [3:0]    pattern;
        out_ready = 1'b0;
        t0 = tx_count;
        rand_valid(); in_valid = 1'b1;
        @(negedge clk);
        n_tests++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_p0_ready: got %b, required 1", in_ready); end
        tick();
        rand_valid();
        @(negedge clk);
        n_tests++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_p1_ready: got %b, required 1", in_ready); end
        tick();
        rand_valid();
        repeat (2) begin
            @(negedge clk);
            n_tests++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL bp_full: got in_ready=%b out_valid=%b, required 0 1", in_ready, out_valid);
            end
            tick();
        end
        out_ready = 1'b1;
        pattern = '0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            pattern[c] = out_valid;
            if (in_valid && in_ready) begin
                tick();
                in_valid = 1'b0;
            end else begin
                tick();
            end
        end
        in_valid = 1'b0;
        n_tests++;
        if (pattern !== 4'b0111) begin n_fail++; $display("FAIL bp_drain_pattern: got %b, required 0111", pattern); end
        @(negedge clk);
        n_tests++;
        if (tx_count !== CW'(t0 + 3)) begin
            n_fail++;
            $display("FAIL bp_tx_count: got %0d, required %0d", tx_count, CW'(t0 + 3));
        end
        tick();
    endtask

    task automatic test_invalid_drop();
        logic [CW-1:0] d0;
        logic [CW-1:0] t0;
        out_ready = 1'b1;
        d0 = drop_count;
        t0 = tx_count;
        rand_valid(); send_one();
        rand_valid(); cmd_opcode = 8'h00; send_one();
        rand_valid(); send_one();
        repeat (3) tick();
        @(negedge clk);
        n_tests++;
        if (drop_count !== CW'(d0 + 1)) begin
            n_fail++;
            $display("FAIL drop_count: got %0d, required %0d", drop_count, CW'(d0 + 1));
        end
        n_tests++;
        if (tx_count !== CW'(t0 + 2)) begin
            n_fail++;
            $display("FAIL drop_tx_count: got %0d, required %0d", tx_count, CW'(t0 + 2));
        end
        tick();
        rand_valid(); cmd_opcode = 8'h00; in_valid = 1'b1;
        repeat ((1 << CW) + 5) tick();
        in_valid = 1'b0;
        tick();
        @(negedge clk);
        n_tests++;
        if (drop_count !== {CW{1'b1}} || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_saturate: got drop=%h out_valid=%b, required %h 0",
                     drop_count, out_valid, {CW{1'b1}});
        end
        tick();
    endtask

    task automatic test_streaming();
        int first;
        int last;
        int outs;
        int ready_drops;
        first = -1; last = -1; outs = 0; ready_drops = 0;
        out_ready = 1'b1;
        for (int c = 0; c < 104; c++) begin
            if (c < 100) begin
                rand_valid();
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (c < 100 && !in_ready) ready_drops++;
            if (out_valid) begin
                if (first < 0) first = c;
                last = c;
                outs++;
            end
            tick();
        end
        in_valid = 1'b0;
        n_tests++;
        if (ready_drops != 0) begin n_fail++; $display("FAIL stream_in_ready: dropped %0d times, required 0", ready_drops); end
        n_tests++;
        if (outs != 100 || first != 1 || last != 100) begin
            n_fail++;
            $display("FAIL stream_timing: got outs=%0d first=%0d last=%0d, required 100 1 100", outs, first, last);
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        rand_valid(); send_one();
        rand_valid(); send_one();
        @(negedge clk);
        n_tests++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_full: got in_ready=%b out_valid=%b, required 0 1", in_ready, out_valid);
        end
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || tx_count !== '0 || drop_count !== '0) begin
            n_fail++;
            $display("FAIL rstmid_state: got out_valid=%b in_ready=%b tx=%0d drop=%0d, required 0 1 0 0",
                     out_valid, in_ready, tx_count, drop_count);
        end
        tick();
        out_ready = 1'b1;
        rand_valid(); send_one();
        @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_latency: out_valid=%b, required 1", out_valid); end
        tick();
        @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b0 || tx_count !== 10'd1) begin
            n_fail++;
            $display("FAIL rstmid_alone: got out_valid=%b tx=%0d, required 0 1", out_valid, tx_count);
        end
        tick();
    endtask

    task automatic test_counter_wrap();
        int n;
        out_ready = 1'b1;
        n = (1 << CW) - int'(tx_count);
        for (int i = 0; i < n; i++) begin
            rand_valid();
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        n_tests++;
        if (tx_count !== '0) begin n_fail++; $display("FAIL wrap_zero: got %0d, required 0", tx_count); end
        tick();
        rand_valid(); send_one();
        tick();
        @(negedge clk);
        n_tests++;
        if (tx_count !== 10'd1) begin n_fail++; $display("FAIL wrap_one: got %0d, required 1", tx_count); end
        n_tests++;
        if (sb_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_left: %0d packets never emitted, required 0", sb_q.size()); end
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_invalid_drop();
        test_streaming();
        test_reset_mid();
        test_counter_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
